// File: rtl/bram_1rport_1wport_read_arbiter_if.sv
// Bundle of the arbiter's request, response, write and BRAM-facing signals.
// slave  : the arbiter side. It takes requests, write commands and BRAM read data,
//          and drives grants, responses and the BRAM next_* inputs.
// master : the environment side, which drives requests, writes and BRAM read data.
// Signals:
//   req_valid/req_index/req_ready : per-requester read request and one-hot grant
//   resp_valid/resp_id/resp_data  : read response, one cycle after the grant
//   wr_byte_en/wr_index/wr_data   : write command; nonzero byte enables mean a write
//   bram_*                        : BRAM next_* inputs and the BRAM last_rdata output
interface bram_1rport_1wport_read_arbiter_if #(
    parameter int unsigned OUTER_WIDTH = 32,
    parameter int unsigned INNER_WIDTH = 32,
    parameter int unsigned NUM_REQ     = 4
);
    localparam int unsigned IW = $clog2(OUTER_WIDTH);
    localparam int unsigned RW = $clog2(NUM_REQ);
    localparam int unsigned BW = INNER_WIDTH / 8;

    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0][IW-1:0]  req_index;
    logic [NUM_REQ-1:0]          req_ready;
    logic                        resp_valid;
    logic [RW-1:0]               resp_id;
    logic [INNER_WIDTH-1:0]      resp_data;
    logic [BW-1:0]               wr_byte_en;
    logic [IW-1:0]               wr_index;
    logic [INNER_WIDTH-1:0]      wr_data;
    logic                        bram_ren;
    logic [IW-1:0]               bram_rindex;
    logic [BW-1:0]               bram_wen_byte;
    logic [IW-1:0]               bram_windex;
    logic [INNER_WIDTH-1:0]      bram_wdata;
    logic [INNER_WIDTH-1:0]      bram_rdata;

    modport slave (
        input  req_valid, req_index, wr_byte_en, wr_index, wr_data, bram_rdata,
        output req_ready, resp_valid, resp_id, resp_data,
               bram_ren, bram_rindex, bram_wen_byte, bram_windex, bram_wdata
    );

    modport master (
        output req_valid, req_index, wr_byte_en, wr_index, wr_data, bram_rdata,
        input  req_ready, resp_valid, resp_id, resp_data,
               bram_ren, bram_rindex, bram_wen_byte, bram_windex, bram_wdata
    );
endinterface

// File: rtl/bram_1rport_1wport_read_arbiter.sv
// Front end for one bram_1rport_1wport. It shares the single read port among NUM_REQ
// requesters using round-robin arbitration, and it passes the write port straight
// through. Read data returns one cycle after the grant, tagged with the requester ID.
// A write to the index being read in the same cycle is merged into the response byte
// by byte, so every read returns post-write data.
// Ports:
//   CLK  : clock
//   nRST : asynchronous reset, active low
//   bus  : bram_1rport_1wport_read_arbiter_if.slave (requests, responses, write, BRAM)
module bram_1rport_1wport_read_arbiter #(
    parameter int unsigned OUTER_WIDTH = 32,
    parameter int unsigned INNER_WIDTH = 32,
    parameter int unsigned NUM_REQ     = 4
) (
    input logic                               CLK,
    input logic                               nRST,
    bram_1rport_1wport_read_arbiter_if.slave  bus
);
    localparam int unsigned IW = $clog2(OUTER_WIDTH);
    localparam int unsigned RW = $clog2(NUM_REQ);
    localparam int unsigned BW = INNER_WIDTH / 8;

    logic [RW-1:0]          rr_ptr_q;
    logic                   rsp_pend_q;
    logic [RW-1:0]          rsp_id_q;
    logic [BW-1:0]          fwd_mask_q;
    logic [INNER_WIDTH-1:0] fwd_data_q;

    logic                   grant;
    logic [RW-1:0]          grant_id;
    logic [RW-1:0]          rr_ptr_d;
    logic [IW-1:0]          rindex;
    logic                   fwd_hit;

    // Scan from rr_ptr upward (mod NUM_REQ) and take the first valid requester.
    always_comb begin
        int unsigned scan;
        grant    = 1'b0;
        grant_id = '0;
        scan     = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan = 32'(rr_ptr_q) + k;
            if (scan >= NUM_REQ) begin
                scan = scan - NUM_REQ;
            end
            if (!grant && bus.req_valid[scan]) begin
                grant    = 1'b1;
                grant_id = RW'(scan);
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            bus.req_ready[i] = grant && (grant_id == RW'(i));
        end
    end

    assign rindex          = grant ? bus.req_index[grant_id] : '0;
    assign bus.bram_ren    = grant;
    assign bus.bram_rindex = rindex;
    assign rr_ptr_d        = (grant_id == RW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    assign bus.bram_wen_byte = bus.wr_byte_en;
    assign bus.bram_windex   = bus.wr_index;
    assign bus.bram_wdata    = bus.wr_data;

    // The BRAM returns the old word when it is read and written at one index in the
    // same cycle. Those write bytes are captured here and merged into the response.
    assign fwd_hit = grant && (|bus.wr_byte_en) && (bus.wr_index == rindex);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rr_ptr_q   <= '0;
            rsp_pend_q <= 1'b0;
            rsp_id_q   <= '0;
            fwd_mask_q <= '0;
            fwd_data_q <= '0;
        end else begin
            rsp_pend_q <= grant;
            if (grant) begin
                rr_ptr_q <= rr_ptr_d;
                rsp_id_q <= grant_id;
            end
            fwd_mask_q <= fwd_hit ? bus.wr_byte_en : '0;
            if (fwd_hit) begin
                fwd_data_q <= bus.wr_data;
            end
        end
    end

    assign bus.resp_valid = rsp_pend_q;
    assign bus.resp_id    = rsp_id_q;

    always_comb begin
        for (int unsigned b = 0; b < BW; b++) begin
            bus.resp_data[8*b +: 8] = fwd_mask_q[b] ? fwd_data_q[8*b +: 8]
                                                    : bus.bram_rdata[8*b +: 8];
        end
    end
endmodule

// File: tb/tb_bram_1rport_1wport_read_arbiter.sv
module tb_bram_1rport_1wport_read_arbiter;
    localparam int unsigned OW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned NR = 4;
    localparam int unsigned IW = $clog2(OW);
    localparam int unsigned RW = $clog2(NR);
    localparam int unsigned BW = DW / 8;

    typedef struct packed {
        logic [RW-1:0] id;
        logic [DW-1:0] data;
    } resp_t;

    logic CLK;
    logic nRST;
    int   checks;
    int   errors;
    resp_t exp_q[$];

    bram_1rport_1wport_read_arbiter_if #(.OUTER_WIDTH(OW), .INNER_WIDTH(DW), .NUM_REQ(NR)) bus ();

    bram_1rport_1wport_read_arbiter #(
        .OUTER_WIDTH (OW),
        .INNER_WIDTH (DW),
        .NUM_REQ     (NR)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural BRAM: registered read of the pre-write word, byte-enabled write.
    logic [DW-1:0] mem [OW];
    always @(posedge CLK) begin
        if (bus.bram_ren) begin
            bus.bram_rdata <= mem[bus.bram_rindex];
        end
        for (int b = 0; b < BW; b++) begin
            if (bus.bram_wen_byte[b]) begin
                mem[bus.bram_windex][8*b +: 8] <= bus.bram_wdata[8*b +: 8];
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    // Monitor: every response seen must match the oldest expected response.
    always @(negedge CLK) begin
        if (bus.resp_valid !== 1'b0) begin
            resp_t e;
            if (exp_q.size() == 0) begin
                check("unexpected_resp_valid", 64'(bus.resp_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("resp_id", 64'(bus.resp_id), 64'(e.id));
                check("resp_data", 64'(bus.resp_data), 64'(e.data));
            end
        end
    end

    task automatic write_word(input logic [IW-1:0] idx, input logic [DW-1:0] data);
        @(posedge CLK); #1;
        bus.req_valid  = '0;
        bus.wr_byte_en = '1;
        bus.wr_index   = idx;
        bus.wr_data    = data;
    endtask

    task automatic idle();
        @(posedge CLK); #1;
        bus.req_valid  = '0;
        bus.wr_byte_en = '0;
    endtask

    // One request cycle; checks the grant and write passthrough, then queues the response.
    task automatic read_cycle(input logic [NR-1:0] valid, input logic [NR-1:0][IW-1:0] idx,
                              input logic [BW-1:0] wen, input logic [IW-1:0] widx,
                              input logic [DW-1:0] wdat, input logic [NR-1:0] exp_ready,
                              input logic [DW-1:0] exp_data, input bit push);
        resp_t e;
        logic [RW-1:0] g;
        @(posedge CLK); #1;
        bus.req_valid  = valid;
        bus.req_index  = idx;
        bus.wr_byte_en = wen;
        bus.wr_index   = widx;
        bus.wr_data    = wdat;
        #1;
        g = '0;
        for (int i = 0; i < NR; i++) begin
            if (exp_ready[i]) g = RW'(i);
        end
        check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
        check("bram_ren", 64'(bus.bram_ren), 64'(|exp_ready));
        check("bram_rindex", 64'(bus.bram_rindex), 64'(idx[g]));
        check("bram_wen_byte", 64'(bus.bram_wen_byte), 64'(wen));
        if (|wen) begin
            check("bram_windex", 64'(bus.bram_windex), 64'(widx));
            check("bram_wdata", 64'(bus.bram_wdata), 64'(wdat));
        end
        if (push) begin
            e.id   = g;
            e.data = exp_data;
            exp_q.push_back(e);
        end
    endtask

    localparam logic [NR-1:0][IW-1:0] RR_IDX = {5'd13, 5'd12, 5'd11, 5'd10};

    initial begin
        checks         = 0;
        errors         = 0;
        nRST           = 1'b0;
        bus.req_valid  = '0;
        bus.req_index  = '0;
        bus.wr_byte_en = '0;
        bus.wr_index   = '0;
        bus.wr_data    = '0;
        #1;
        check("reset_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("reset_resp_id", 64'(bus.resp_id), 64'd0);
        check("idle_req_ready", 64'(bus.req_ready), 64'd0);
        check("idle_bram_rindex", 64'(bus.bram_rindex), 64'd0);
        #20;
        nRST = 1'b1;

        write_word(5'd5, 32'hDEADBEEF);
        write_word(5'd7, 32'h11223344);
        write_word(5'd2, 32'h00000000);
        for (int i = 0; i < 4; i++) begin
            write_word(5'(10 + i), 32'hA0000000 + 32'(i));
        end
        idle();

        // Single read of index 5 from requester 0.
        read_cycle(4'b0001, {5'd0, 5'd0, 5'd0, 5'd5}, '0, '0, '0, 4'b0001, 32'hDEADBEEF, 1);
        idle();

        // Fresh reset, then all four requesters continuously: grants 0,1,2,3,0,1,2,3.
        @(negedge CLK); nRST = 1'b0;
        @(negedge CLK); nRST = 1'b1;
        for (int c = 0; c < 8; c++) begin
            read_cycle(4'b1111, RR_IDX, '0, '0, '0, 4'(1 << (c % 4)),
                       32'hA0000000 + 32'(c % 4), 1);
        end
        // rr_ptr is 0 here; a lone grant to 2 moves it to 3.
        read_cycle(4'b0100, {5'd0, 5'd5, 5'd0, 5'd0}, '0, '0, '0, 4'b0100, 32'hDEADBEEF, 1);
        // Skip and wrap: scanning 3,0,1 picks 1, then scanning 2,3 picks 3, and then 0.
        read_cycle(4'b0110, RR_IDX, '0, '0, '0, 4'b0010, 32'hA0000001, 1);
        read_cycle(4'b1001, RR_IDX, '0, '0, '0, 4'b1000, 32'hA0000003, 1);
        read_cycle(4'b1111, RR_IDX, '0, '0, '0, 4'b0001, 32'hA0000000, 1);
        idle();

        // Collision: partial write merges into the same-cycle read, then persists.
        read_cycle(4'b0001, {5'd0, 5'd0, 5'd0, 5'd7}, 4'b0101, 5'd7, 32'hAABBCCDD,
                   4'b0001, 32'h11BB33DD, 1);
        read_cycle(4'b0001, {5'd0, 5'd0, 5'd0, 5'd7}, '0, '0, '0, 4'b0001, 32'h11BB33DD, 1);

        // Different-index write is independent; a write during the response cycle is ignored.
        read_cycle(4'b0001, {5'd0, 5'd0, 5'd0, 5'd2}, 4'b1111, 5'd3, 32'h12345678,
                   4'b0001, 32'h00000000, 1);
        @(posedge CLK); #1;
        bus.req_valid  = '0;
        bus.wr_byte_en = '1;
        bus.wr_index   = 5'd2;
        bus.wr_data    = 32'hFFFFFFFF;
        idle();

        // Reset mid-flight: the pending response is dropped, and requester 1 wins afterwards.
        read_cycle(4'b0001, {5'd0, 5'd0, 5'd0, 5'd5}, '0, '0, '0, 4'b0001, 32'hDEADBEEF, 0);
        @(posedge CLK); #1;
        bus.req_valid = '0;
        check("pending_before_reset", 64'(bus.resp_valid), 64'd1);
        nRST = 1'b0;
        #1;
        check("midflight_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("midflight_resp_id", 64'(bus.resp_id), 64'd0);
        @(negedge CLK); nRST = 1'b1;
        read_cycle(4'b0010, RR_IDX, '0, '0, '0, 4'b0010, 32'hA0000001, 1);
        idle();
        idle();
        idle();
        check("responses_outstanding", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
